periph_bus_master: RTL and testbench
====================================

# periph_bus_master

Initiator side of the team's peripheral register bus. Accepts single read/write commands from an upstream controller (debug port, boot sequencer), drives the single-cycle peripheral strobes toward register slaves such as the UART control block, and returns completion data. Reads to unmapped addresses get no response from the slave, so this block bounds them with a timeout. Sits between the command source and the shared peripheral bus in the clk_125 domain.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, read-response wait limit in cycles; legal range 2..255

Ports:
- clk_125  in  1  sole clock
- rst_n_125  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  [31:16] slave base, [15:0] register offset
- cmd_wdata  in  32  write data
- rsp_valid  out  1  completion available
- rsp_ready  in  1  completion consumed when high with rsp_valid
- rsp_rdata  out  32  read data; 0 for writes and timeouts
- rsp_err  out  1  1 = read timed out
- peripheral_addr_out  out  32  bus address
- peripheral_data_wr  out  32  bus write data
- peripheral_write_en  out  1  one-cycle write strobe
- peripheral_read_en  out  1  one-cycle read strobe
- peripheral_data_rd  in  32  slave read data
- peripheral_data_rd_en  in  1  slave read-data valid, one cycle
- timeout_cnt  out  8  saturating count of read timeouts

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_write/addr/wdata and go to ISSUE.
- ISSUE: exactly one cycle. Assert the write or read strobe with the latched addr and data.
  - Write: go to RESP with rsp_err=0 and rsp_rdata=0. Writes are posted; there is no slave ack.
  - Read: clear wait counter, go to WAIT_RD.
- WAIT_RD:
  - If peripheral_data_rd_en: capture peripheral_data_rd, rsp_err=0, go to RESP.
  - Else if counter == TIMEOUT_CYCLES-1: rsp_rdata=0, rsp_err=1, timeout_cnt += 1 (saturating at 255), go to RESP.
  - Else counter += 1.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready, then go to IDLE.
- peripheral_data_rd_en outside WAIT_RD is ignored. This includes a late response after a timeout.
- Strobes are never asserted outside ISSUE. At most one transaction is outstanding.
- peripheral_addr_out and peripheral_data_wr hold their last latched values outside ISSUE. Slaves ignore them without a strobe.

## Timing
- Reset (on the clk_125 edge with rst_n_125=0): state=IDLE; all outputs 0; counters 0; timeout_cnt 0. cmd_ready=0 while rst_n_125 is low.
- Command accepted at edge T. Strobe is high during cycle T+1 only.
- Write: rsp_valid from T+2.
- Read: slaves return data_rd_en the cycle after the strobe (T+2), giving rsp_valid from T+3.
- Timeout: rsp_valid from T+2+TIMEOUT_CYCLES.
- Data and timeout in the same cycle: data wins, no error.
- Reset mid-transaction: abort with no response. Strobes are low after the reset edge.
- Back-to-back throughput: cmd_ready returns the cycle after the rsp handshake. Minimum is 3 cycles per write and 4 per read with rsp_ready tied high.

## Structure
- Shared package periph_bus_pkg:
  - state enum
  - PERIPH_DATA_W=32
  - PERIPH_ADDR_W=32
  - PERIPH_TIMEOUT_DEF=16
  - PERIPH_ERR_RDATA=32'h0
- Single module. The 8-bit saturating counter is small enough to stay inline; no sub-module.

## Test plan
- Write 0x0001_0000 / 0x0000_0F3F with a UART control slave at base 0x0001:
  - write_en high during T+1 only, with that addr and data
  - rsp_valid at T+2, err=0
  - readback of 0x0001_0000 returns 0x0000_0F3F
- Read 0x0001_1004 with the slave returning 0x0000_0005 at T+2: rsp_rdata=0x5, err=0, rsp_valid at T+3.
- Read unmapped 0x0001_2000 with TIMEOUT_CYCLES=16:
  - rsp_valid at T+18, err=1, rdata=0
  - timeout_cnt=1
  - an injected late data_rd_en at T+20 is ignored
- rsp_ready held low for 5 cycles with cmd_valid held high:
  - response held stable
  - cmd_ready=0
  - no second strobe until the handshake completes
- Reset asserted during WAIT_RD:
  - next cycle all outputs 0, state IDLE
  - slave data_rd_en one cycle later produces no rsp_valid
- 260 consecutive timed-out reads: timeout_cnt saturates at 255 and stays there.

Source files
------------

// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg
//   Shared definitions for the peripheral register bus initiator:
//   - state_e           : transaction FSM states
//   - PERIPH_DATA_W     : bus data width
//   - PERIPH_ADDR_W     : bus address width ([31:16] slave base, [15:0] offset)
//   - PERIPH_TIMEOUT_DEF: default read-response wait limit in cycles
//   - PERIPH_ERR_RDATA  : read data returned with a timed-out read
//   - sat_inc8()        : 8-bit saturating increment for event counters
package periph_bus_pkg;

  localparam int PERIPH_DATA_W      = 32;
  localparam int PERIPH_ADDR_W      = 32;
  localparam int PERIPH_TIMEOUT_DEF = 16;

  localparam logic [PERIPH_DATA_W-1:0] PERIPH_ERR_RDATA = 32'h0;

  // Width of the wait counter and the timeout event counter.
  localparam int PERIPH_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PERIPH_CNT_W-1:0] sat_inc8(input logic [PERIPH_CNT_W-1:0] v);
    logic [PERIPH_CNT_W-1:0] r;
    r = (v == {PERIPH_CNT_W{1'b1}}) ? v : v + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/periph_bus_master.sv
// periph_bus_master
//   Initiator for the peripheral register bus. Takes one read or write
//   command at a time from an upstream controller, drives a single-cycle
//   strobe toward the register slaves, and returns a completion.
//   Reads to unmapped addresses never get a slave response, so the wait
//   for read data is bounded by TIMEOUT_CYCLES (legal range 2..255).
//
// Ports
//   clk_125, rst_n_125         : clock, synchronous active-low reset
//   cmd_valid/ready/write/addr/wdata : command channel (valid/ready)
//   rsp_valid/ready/rdata/err  : completion channel (valid/ready);
//                                rdata is 0 for writes and timeouts,
//                                err flags a timed-out read
//   peripheral_addr_out/data_wr : bus address / write data (hold last value)
//   peripheral_write_en/read_en : one-cycle strobes, only in ISSUE
//   peripheral_data_rd/_rd_en   : slave read data and its one-cycle valid
//   timeout_cnt                 : saturating count of read timeouts
module periph_bus_master
  import periph_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = PERIPH_TIMEOUT_DEF
) (
  input  logic                     clk_125,
  input  logic                     rst_n_125,

  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [PERIPH_ADDR_W-1:0] cmd_addr,
  input  logic [PERIPH_DATA_W-1:0] cmd_wdata,

  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [PERIPH_DATA_W-1:0] rsp_rdata,
  output logic                     rsp_err,

  output logic [PERIPH_ADDR_W-1:0] peripheral_addr_out,
  output logic [PERIPH_DATA_W-1:0] peripheral_data_wr,
  output logic                     peripheral_write_en,
  output logic                     peripheral_read_en,
  input  logic [PERIPH_DATA_W-1:0] peripheral_data_rd,
  input  logic                     peripheral_data_rd_en,

  output logic [PERIPH_CNT_W-1:0]  timeout_cnt
);

  // Last value of the wait counter before a read is declared timed out.
  localparam logic [PERIPH_CNT_W-1:0] WAIT_LAST = PERIPH_CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                   state_q, state_d;
  logic                     write_q, write_d;
  logic [PERIPH_ADDR_W-1:0] addr_q, addr_d;
  logic [PERIPH_DATA_W-1:0] wdata_q, wdata_d;
  logic [PERIPH_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [PERIPH_DATA_W-1:0] rdata_q, rdata_d;
  logic                     err_q, err_d;
  logic [PERIPH_CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;

  logic                     wait_expired;

  assign wait_expired = (wait_cnt_q == WAIT_LAST);

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_125) begin
    if (!rst_n_125) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Writes are posted: no slave acknowledge to wait for.
        state_d = write_q ? RESP : WAIT_RD;
      end
      WAIT_RD: begin
        if (peripheral_data_rd_en || wait_expired) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath register updates
  // ---------------------------------------------------------------------
  always_comb begin
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wait_cnt_d = wait_cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    tmo_cnt_d  = tmo_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
        end
      end
      ISSUE: begin
        wait_cnt_d = '0;
        if (write_q) begin
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      WAIT_RD: begin
        // Data arriving on the same cycle as the timeout wins.
        if (peripheral_data_rd_en) begin
          rdata_d = peripheral_data_rd;
          err_d   = 1'b0;
        end else if (wait_expired) begin
          rdata_d   = PERIPH_ERR_RDATA;
          err_d     = 1'b1;
          tmo_cnt_d = sat_inc8(tmo_cnt_q);
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      RESP: begin
        // Completion fields are frozen until the handshake.
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    // Gated with reset so no command is accepted while reset is held.
    cmd_ready           = rst_n_125 && (state_q == IDLE);
    peripheral_write_en = (state_q == ISSUE) &&  write_q;
    peripheral_read_en  = (state_q == ISSUE) && !write_q;
    rsp_valid           = (state_q == RESP);
    rsp_rdata           = rdata_q;
    rsp_err             = err_q;
    peripheral_addr_out = addr_q;
    peripheral_data_wr  = wdata_q;
    timeout_cnt         = tmo_cnt_q;
  end

endmodule

// File: tb/tb_periph_bus_master.sv
// tb_periph_bus_master
//   Directed plus randomized transactions against periph_bus_master with a
//   behavioural slave/completion model kept in the bench.
module tb_periph_bus_master;

  localparam int TO = 16;

  logic        clk_125 = 1'b0;
  logic        rst_n_125;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] peripheral_addr_out;
  logic [31:0] peripheral_data_wr;
  logic        peripheral_write_en;
  logic        peripheral_read_en;
  logic [31:0] peripheral_data_rd;
  logic        peripheral_data_rd_en;
  logic [7:0]  timeout_cnt;

  always #4 clk_125 = ~clk_125;

  periph_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_125              (clk_125),
    .rst_n_125            (rst_n_125),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_write            (cmd_write),
    .cmd_addr             (cmd_addr),
    .cmd_wdata            (cmd_wdata),
    .rsp_valid            (rsp_valid),
    .rsp_ready            (rsp_ready),
    .rsp_rdata            (rsp_rdata),
    .rsp_err              (rsp_err),
    .peripheral_addr_out  (peripheral_addr_out),
    .peripheral_data_wr   (peripheral_data_wr),
    .peripheral_write_en  (peripheral_write_en),
    .peripheral_read_en   (peripheral_read_en),
    .peripheral_data_rd   (peripheral_data_rd),
    .peripheral_data_rd_en(peripheral_data_rd_en),
    .timeout_cnt          (timeout_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Slave register contents and expected timeout count.
  logic [31:0] mem [logic [31:0]];
  int          tmo_model = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_125);
    #1;
  endtask

  // One complete transaction. resp_k: cycle (counted from the accept edge)
  // in which the slave pulses data_rd_en; 0 = no response. hold: cycles
  // rsp_ready stays low after rsp_valid. late_k: cycle of a stray data_rd_en.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int resp_k, input int hold, input int late_k);
    logic [31:0] exp_rdata;
    logic [31:0] slave_val;
    logic [31:0] held_rdata;
    bit          exp_err;
    bit          seen;
    int          exp_lat;
    int          k;

    slave_val = mem.exists(addr) ? mem[addr] : 32'h0;
    if (wr) begin
      exp_lat = 2; exp_rdata = 32'h0; exp_err = 1'b0;
    end else if (resp_k >= 2 && resp_k <= TO + 1) begin
      exp_lat = resp_k + 1; exp_rdata = slave_val; exp_err = 1'b0;
    end else begin
      exp_lat = TO + 2; exp_rdata = 32'h0; exp_err = 1'b1;
      tmo_model = (tmo_model < 255) ? tmo_model + 1 : 255;
    end

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    tick(); k = 1;
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    chk("strobe_issue", 32'({peripheral_write_en, peripheral_read_en}), wr ? 32'd2 : 32'd1);
    chk("addr_issue", peripheral_addr_out, addr);
    if (wr) chk("wdata_issue", peripheral_data_wr, wdata);

    seen = 1'b0;
    while (!seen && k < TO + 6) begin
      tick(); k++;
      peripheral_data_rd_en = 1'b0;
      if (rsp_valid) begin
        seen = 1'b1;
      end else begin
        chk("strobe_wait", 32'({peripheral_write_en, peripheral_read_en}), 32'd0);
        if (!wr && k == resp_k) begin
          peripheral_data_rd_en = 1'b1;
          peripheral_data_rd    = slave_val;
        end
      end
    end
    chk("rsp_seen", 32'(seen), 32'd1);
    chk("rsp_latency", 32'(k), 32'(exp_lat));
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("timeout_cnt", 32'(timeout_cnt), 32'(tmo_model));
    held_rdata = rsp_rdata;

    for (int h = 0; h < hold; h++) begin
      if (h == 0) begin
        // A new command is offered but must not be taken yet.
        cmd_valid = 1'b1; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
      end
      tick(); k++;
      peripheral_data_rd_en = (k == late_k);
      peripheral_data_rd    = 32'hDEAD_BEEF;
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, exp_rdata);
      chk("hold_err", 32'(rsp_err), 32'(exp_err));
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("hold_strobe", 32'({peripheral_write_en, peripheral_read_en}), 32'd0);
    end

    cmd_valid = 1'b0; peripheral_data_rd_en = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
    chk("cmd_ready_after_hs", 32'(cmd_ready), 32'd1);
    chk("strobe_after_hs", 32'({peripheral_write_en, peripheral_read_en}), 32'd0);

    if (wr) mem[addr] = wdata;
    $display("txn %s addr=%h wdata=%h rdata=%h err=%0d lat=%0d tmo=%0d",
             wr ? "WR" : "RD", addr, wdata, held_rdata, rsp_err, exp_lat, timeout_cnt);
  endtask

  initial begin
    logic [31:0] a;
    bit          w;
    int          rk;

    rst_n_125 = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; peripheral_data_rd = '0; peripheral_data_rd_en = 1'b0;
    tick(); tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_strobes", 32'({peripheral_write_en, peripheral_read_en}), 32'd0);
    chk("rst_addr", peripheral_addr_out, 32'd0);
    chk("rst_wdata", peripheral_data_wr, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_tmo", 32'(timeout_cnt), 32'd0);
    rst_n_125 = 1'b1;
    tick();

    mem[32'h0001_1004] = 32'h0000_0005;

    // Directed cases
    run_txn(1'b1, 32'h0001_0000, 32'h0000_0F3F, 0, 0, 0);
    run_txn(1'b0, 32'h0001_0000, 32'h0, 2, 0, 0);
    run_txn(1'b0, 32'h0001_1004, 32'h0, 2, 0, 0);
    run_txn(1'b0, 32'h0001_2000, 32'h0, 0, 4, 20);
    run_txn(1'b1, 32'h0001_0010, 32'hA5A5_5A5A, 0, 5, 0);
    run_txn(1'b0, 32'h0001_0010, 32'h0, 2, 5, 0);
    run_txn(1'b0, 32'h0001_0000, 32'h0, TO + 1, 0, 0);
    run_txn(1'b0, 32'h0001_0000, 32'h0, TO + 2, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom);
      a = {16'h0001, 3'b000, 13'($urandom)};
      case ($urandom_range(0, 3))
        0:       rk = 0;
        1:       rk = $urandom_range(2, TO + 1);
        default: rk = 2;
      endcase
      run_txn(w, a, $urandom, rk, $urandom_range(0, 3), 0);
    end

    // Reset while waiting for read data
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0001_2000; cmd_wdata = 32'h0;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    rst_n_125 = 1'b0;
    tick();
    tmo_model = 0;
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_strobes", 32'({peripheral_write_en, peripheral_read_en}), 32'd0);
    chk("midrst_addr", peripheral_addr_out, 32'd0);
    chk("midrst_rdata", rsp_rdata, 32'd0);
    chk("midrst_err", 32'(rsp_err), 32'd0);
    chk("midrst_tmo", 32'(timeout_cnt), 32'(tmo_model));
    rst_n_125 = 1'b1;
    peripheral_data_rd_en = 1'b1; peripheral_data_rd = 32'h1234_5678;
    tick();
    peripheral_data_rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("postrst_cmd_ready", 32'(cmd_ready), 32'd1);
      tick();
    end
    $display("txn RST mid-read aborted, no response");

    // Timeout counter saturation
    for (int i = 0; i < 260; i++) begin
      run_txn(1'b0, 32'h0001_2000, 32'h0, 0, 0, 0);
    end
    chk("tmo_saturated", 32'(timeout_cnt), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
